// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants and latency lookup for the ALU share controller
//
// Purpose : function codes understood by the shared 16-bit ALU, the controller
//           state encoding, and the per-function operand hold latency.
// Ports   : none (package).
package alu_ctrl_pkg;

  // ALU function codes
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;
  localparam logic [3:0] FN_AND = 4'b1000;
  localparam logic [3:0] FN_OR  = 4'b1001;
  localparam logic [3:0] FN_MEM = 4'b1100;

  // Controller states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  // Number of cycles the operands must be held at the ALU for a given code.
  // Only MUL and DIV are multi-cycle paths; everything else, including
  // undefined codes, settles in a single cycle.
  function automatic int unsigned op_lat(input logic [3:0]  fn,
                                         input int unsigned mul_lat,
                                         input int unsigned div_lat);
    case (fn)
      FN_MUL:  return mul_lat;
      FN_DIV:  return div_lat;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-requester round-robin arbiter for the ALU share controller
//
// Purpose : picks one of two requesters when enabled; on a tie the requester
//           that did not win last time is chosen.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           en             - arbitration enable (controller idle)
//           req0, req1     - requests
//           gnt0, gnt1     - combinational one-hot grant, only while en
//           win_id         - index of the requester that would be granted
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic win_id
);

  // Last winner. Resets to 1 so requester 0 takes the first tie.
  logic lp;

  // Requester 1 wins if it is alone, or on a tie when requester 0 won last.
  assign win_id = req1 & (~req0 | ~lp);

  assign gnt0 = en & req0 & ~win_id;
  assign gnt1 = en & req1 &  win_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp <= 1'b1;
    end else if (gnt0 | gnt1) begin
      lp <= win_id;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - sequencer/arbiter sharing one 16-bit ALU between EX stage and AGU
//
// Purpose : accepts one operation at a time from two requesters (0: pipeline
//           EX stage, 1: address-generation unit), holds registered operands
//           at the ALU for the operation's latency, then returns the captured
//           result and flags tagged with the requester id.
// Ports   : clk, rst_n                 - clock, asynchronous active-low reset
//           req0/fn0/a0/b0             - requester 0 request, function, operands
//           req1/fn1/a1/b1             - requester 1 request, function, operands
//           gnt0, gnt1                 - combinational accept strobes (idle only)
//           alu_a, alu_b, alu_fn       - registered operands/function to the ALU
//           alu_out, alu_o/n/z         - ALU result and flags
//           rsp_valid, rsp_id          - one-cycle result strobe and owner
//           rsp_out, rsp_o/n/z         - captured result and flags
//           div0_err                   - divide-by-zero trap strobe (optional)
//           busy                       - high while an operation executes
// Options : ALU_SHARE_DIV0_TRAP_EN - divide by zero is answered locally with an
//           all-ones result and overflow flag instead of being sent to the ALU,
//           and the div0_err port exists.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [3:0]         fn0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [3:0]         fn1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_fn,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_o,
  input  logic               alu_n,
  input  logic               alu_z,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_out,
  output logic               rsp_o,
  output logic               rsp_n,
  output logic               rsp_z,
`ifdef ALU_SHARE_DIV0_TRAP_EN
  output logic               div0_err,
`endif
  output logic               busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cur_id;

  logic             arb_en;
  logic             win_id;
  logic             accept;

  logic [3:0]       sel_fn;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [CNT_W-1:0] cnt_load;
  logic             trap_sel;

  // Arbitration is only open while idle. Gating with rst_n keeps the grants
  // low while reset is held, so every output reads 0 during reset.
  assign arb_en = (state == ST_IDLE) & rst_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en),
    .req0   (req0),
    .req1   (req1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .win_id (win_id)
  );

  assign accept = gnt0 | gnt1;
  assign busy   = (state == ST_EXEC);

  assign sel_fn = win_id ? fn1 : fn0;
  assign sel_a  = win_id ? a1  : a0;
  assign sel_b  = win_id ? b1  : b0;

`ifdef ALU_SHARE_DIV0_TRAP_EN
  logic trap_q;
  assign trap_sel = (sel_fn == FN_DIV) && (sel_b == '0);
`else
  assign trap_sel = 1'b0;
`endif

  // A trapped divide spends a single EXEC cycle so its response lands at T+2.
  always_comb begin
    cnt_load = '0;
    if (!trap_sel) begin
      cnt_load = CNT_W'(op_lat(sel_fn, MUL_LAT, DIV_LAT) - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_id    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fn    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_o     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_z     <= 1'b0;
`ifdef ALU_SHARE_DIV0_TRAP_EN
      trap_q    <= 1'b0;
      div0_err  <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef ALU_SHARE_DIV0_TRAP_EN
      div0_err  <= 1'b0;
`endif
      if (state == ST_IDLE) begin
        if (accept) begin
          state  <= ST_EXEC;
          cnt    <= cnt_load;
          cur_id <= win_id;
          // A trapped divide leaves the ALU inputs untouched.
          if (!trap_sel) begin
            alu_fn <= sel_fn;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
          end
`ifdef ALU_SHARE_DIV0_TRAP_EN
          trap_q <= trap_sel;
`endif
        end
      end else begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
`ifdef ALU_SHARE_DIV0_TRAP_EN
          if (trap_q) begin
            rsp_out  <= '1;
            rsp_o    <= 1'b1;
            rsp_n    <= 1'b0;
            rsp_z    <= 1'b0;
            div0_err <= 1'b1;
            trap_q   <= 1'b0;
          end else begin
            rsp_out <= alu_out;
            rsp_o   <= alu_o;
            rsp_n   <= alu_n;
            rsp_z   <= alu_z;
          end
`else
          rsp_out <= alu_out;
          rsp_o   <= alu_o;
          rsp_n   <= alu_n;
          rsp_z   <= alu_z;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

  localparam int WIDTH = 16;

  logic               clk;
  logic               rst_n;
  logic               req0, req1;
  logic [3:0]         fn0, fn1;
  logic [WIDTH-1:0]   a0, b0, a1, b1;
  logic               gnt0, gnt1;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [3:0]         alu_fn;
  logic [2*WIDTH-1:0] alu_out;
  logic               alu_o, alu_n, alu_z;
  logic               rsp_valid, rsp_id;
  logic [2*WIDTH-1:0] rsp_out;
  logic               rsp_o, rsp_n, rsp_z;
  logic               busy;
`ifdef ALU_SHARE_DIV0_TRAP_EN
  logic               div0_err;
`endif

  int checks   = 0;
  int failures = 0;

  alu_share_ctrl #(.WIDTH(WIDTH), .MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .fn0       (fn0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .fn1       (fn1),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fn    (alu_fn),
    .alu_out   (alu_out),
    .alu_o     (alu_o),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_o     (rsp_o),
    .rsp_n     (rsp_n),
    .rsp_z     (rsp_z),
`ifdef ALU_SHARE_DIV0_TRAP_EN
    .div0_err  (div0_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU driven by the controller's registered operands.
  always_comb begin
    alu_out = '0;
    case (alu_fn)
      4'b0000: alu_out = {16'h0, alu_a} + {16'h0, alu_b};
      4'b0001: alu_out = {16'h0, alu_a} - {16'h0, alu_b};
      4'b0100: alu_out = {16'h0, alu_a} * {16'h0, alu_b};
      4'b0101: alu_out = (alu_b != 0) ? {16'h0, alu_a / alu_b} : 32'h0;
      4'b1000: alu_out = {16'h0, alu_a & alu_b};
      4'b1001: alu_out = {16'h0, alu_a | alu_b};
      default: alu_out = '0;
    endcase
    alu_o = 1'b0;
    alu_n = alu_out[31];
    alu_z = (alu_out == 0);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seen;

  initial begin
    rst_n = 1'b0;
    req0 = 0; fn0 = 0; a0 = 0; b0 = 0;
    req1 = 0; fn1 = 0; a1 = 0; b1 = 0;
    tick();
    tick();

    // Reset state
    check_eq("rst_busy",      busy,      0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_alu_fn",    alu_fn,    0);
    check_eq("rst_alu_a",     alu_a,     0);
    check_eq("rst_rsp_out",   rsp_out,   0);
    rst_n = 1'b1;
    tick();

    // 1) req0 ADD 3+4
    req0 = 1; fn0 = 4'b0000; a0 = 16'h0003; b0 = 16'h0004;
    #1;
    check_eq("add_gnt0", gnt0, 1);
    check_eq("add_gnt1", gnt1, 0);
    tick(); req0 = 0;
    check_eq("add_alu_fn", alu_fn, 4'b0000);
    check_eq("add_alu_a",  alu_a,  16'h0003);
    check_eq("add_alu_b",  alu_b,  16'h0004);
    check_eq("add_busy",   busy,   1);
    check_eq("add_no_rsp", rsp_valid, 0);
    tick();
    check_eq("add_rsp_valid", rsp_valid, 1);
    check_eq("add_rsp_id",    rsp_id,    0);
    check_eq("add_rsp_out",   rsp_out,   32'h0000_0007);
    check_eq("add_rsp_z",     rsp_z,     0);
    check_eq("add_busy_end",  busy,      0);
    tick();
    check_eq("add_rsp_drop", rsp_valid, 0);
    check_eq("add_rsp_hold", rsp_out,   32'h0000_0007);
`ifdef ALU_SHARE_DIV0_TRAP_EN
    check_eq("add_div0_err", div0_err, 0);
`endif

    // 2) req1 MUL 3*5
    req1 = 1; fn1 = 4'b0100; a1 = 16'h0003; b1 = 16'h0005;
    #1;
    check_eq("mul_gnt1", gnt1, 1);
    tick(); req1 = 0;
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("mul_fn_T%0d", i),   alu_fn, 4'b0100);
      check_eq($sformatf("mul_a_T%0d", i),    alu_a,  16'h0003);
      check_eq($sformatf("mul_b_T%0d", i),    alu_b,  16'h0005);
      check_eq($sformatf("mul_busy_T%0d", i), busy,   1);
      check_eq($sformatf("mul_rv_T%0d", i),   rsp_valid, 0);
      tick();
    end
    check_eq("mul_rsp_valid", rsp_valid, 1);
    check_eq("mul_rsp_id",    rsp_id,    1);
    check_eq("mul_rsp_out",   rsp_out,   32'h0000_000F);
    tick();

    // 3) both requesting SUB 5-5 continuously: grants alternate 0,1,0,1
    req0 = 1; fn0 = 4'b0001; a0 = 16'h0005; b0 = 16'h0005;
    req1 = 1; fn1 = 4'b0001; a1 = 16'h0005; b1 = 16'h0005;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr_gnt0_%0d", k), gnt0, (k % 2 == 0) ? 1 : 0);
      check_eq($sformatf("rr_gnt1_%0d", k), gnt1, (k % 2 == 1) ? 1 : 0);
      tick();
      check_eq($sformatf("rr_exec_gnt_%0d", k), {gnt0, gnt1}, 2'b00);
      tick();
      check_eq($sformatf("rr_rv_%0d", k),  rsp_valid, 1);
      check_eq($sformatf("rr_id_%0d", k),  rsp_id,    (k % 2 == 1) ? 1 : 0);
      check_eq($sformatf("rr_out_%0d", k), rsp_out,   0);
      check_eq($sformatf("rr_z_%0d", k),   rsp_z,     1);
    end
    req0 = 0; req1 = 0;
    tick();

    // 4) req0 DIV 8/2, req1 OR raised at T+3 waits until DIV response
    req0 = 1; fn0 = 4'b0101; a0 = 16'h0008; b0 = 16'h0002;
    #1;
    check_eq("div_gnt0", gnt0, 1);
    tick(); req0 = 0;   // T+1
    tick();             // T+2
    tick();             // T+3
    req1 = 1; fn1 = 4'b1001; a1 = 16'h00F0; b1 = 16'h000F;
    #1;
    for (int c = 3; c <= 8; c++) begin
      check_eq($sformatf("div_hold_gnt1_T%0d", c), gnt1, 0);
      tick();
    end
    check_eq("div_rsp_valid", rsp_valid, 1);
    check_eq("div_rsp_out",   rsp_out,   32'h0000_0004);
    check_eq("div_rsp_id",    rsp_id,    0);
    check_eq("or_gnt1_T9",    gnt1,      1);
    tick(); req1 = 0;
    check_eq("or_alu_fn", alu_fn, 4'b1001);
    tick();
    check_eq("or_rsp_valid", rsp_valid, 1);
    check_eq("or_rsp_out",   rsp_out,   32'h0000_00FF);
    check_eq("or_rsp_id",    rsp_id,    1);
    tick();

    // 5) reset mid-DIV: abort, no response, tie goes to requester 0
    req0 = 1; fn0 = 4'b0101; a0 = 16'h0009; b0 = 16'h0003;
    #1;
    check_eq("abort_gnt0", gnt0, 1);
    tick(); req0 = 0;
    tick();
    tick();             // T+3
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy",    busy,      0);
    check_eq("abort_alu_fn",  alu_fn,    0);
    check_eq("abort_alu_a",   alu_a,     0);
    check_eq("abort_rsp_out", rsp_out,   0);
    check_eq("abort_rsp_id",  rsp_id,    0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check_eq("abort_no_rsp", seen, 0);
    req0 = 1; fn0 = 4'b0000; a0 = 16'h0001; b0 = 16'h0002;
    req1 = 1; fn1 = 4'b0000; a1 = 16'h0010; b1 = 16'h0020;
    #1;
    check_eq("post_rst_gnt0", gnt0, 1);
    check_eq("post_rst_gnt1", gnt1, 0);
    tick(); req0 = 0; req1 = 0;
    tick();
    check_eq("post_rst_rv",  rsp_valid, 1);
    check_eq("post_rst_out", rsp_out,   32'h0000_0003);
    tick();

    // 6) divide by zero
    req0 = 1; fn0 = 4'b0101; a0 = 16'h0007; b0 = 16'h0000;
    #1;
    check_eq("d0_gnt0", gnt0, 1);
    tick(); req0 = 0;
`ifdef ALU_SHARE_DIV0_TRAP_EN
    check_eq("d0_alu_fn_kept", alu_fn, 4'b0000);
    check_eq("d0_alu_a_kept",  alu_a,  16'h0001);
    check_eq("d0_alu_b_kept",  alu_b,  16'h0002);
    tick();
    check_eq("d0_rsp_valid", rsp_valid, 1);
    check_eq("d0_div0_err",  div0_err,  1);
    check_eq("d0_rsp_out",   rsp_out,   32'hFFFF_FFFF);
    check_eq("d0_rsp_o",     rsp_o,     1);
    check_eq("d0_rsp_n",     rsp_n,     0);
    check_eq("d0_rsp_z",     rsp_z,     0);
    tick();
    check_eq("d0_err_drop", div0_err, 0);
`else
    check_eq("d0_alu_fn", alu_fn, 4'b0101);
    check_eq("d0_alu_b",  alu_b,  16'h0000);
    tick();
    check_eq("d0_no_early_rsp", rsp_valid, 0);
    for (int c = 2; c < 9; c++) tick();
    check_eq("d0_rsp_valid", rsp_valid, 1);
    check_eq("d0_rsp_out",   rsp_out,   32'h0000_0000);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
